fifo_rd_stream: RTL



---
 rtl/fifo_rd_stream.sv | 71 +++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// Drains a FIFO through its rd_en/empty/valid read port into a valid/ready stream via a 3-entry prefetch buffer.
// Data reaches m_tvalid two cycles after rd_en; reads stop when buffer plus in-flight reaches 3, so nothing is dropped under backpressure.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_valid,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  input  logic                  flush,
  output logic [1:0]            buf_count,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic                  err_unexp_valid
);

  logic [DATA_WIDTH-1:0] mem [3];
  logic [1:0]            head;
  logic [1:0]            tail;
  logic                  inflight;
  logic                  flush_pending;
  logic                  push;
  logic                  pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue only from registered occupancy, so m_tready never reaches fifo_rd_en.
  assign fifo_rd_en = ~rst & ~fifo_empty & ~flush &
                      (({1'b0, buf_count} + {2'b00, inflight}) < 3'd3);
  assign push       = fifo_valid & inflight & ~flush & ~flush_pending;
  assign pop        = m_tvalid & m_tready;
  assign m_tvalid   = (buf_count != 2'd0);
  assign m_tdata    = mem[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head            <= 2'd0;
      tail            <= 2'd0;
      buf_count       <= 2'd0;
      inflight        <= 1'b0;
      flush_pending   <= 1'b0;
      beat_count      <= '0;
      err_unexp_valid <= 1'b0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      inflight      <= fifo_rd_en;
      flush_pending <= flush & inflight;
      // A word with no read behind it, or a read that never returned.
      if (fifo_valid != inflight) err_unexp_valid <= 1'b1;
      if (pop) beat_count <= beat_count + CNT_WIDTH'(1);
      if (push) mem[tail] <= fifo_dout;
      if (flush) begin
        head      <= 2'd0;
        tail      <= 2'd0;
        buf_count <= 2'd0;
      end else begin
        if (push) tail <= ptr_inc(tail);
        if (pop)  head <= ptr_inc(head);
        buf_count <= buf_count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule
